// File: rtl/fc_input_streamer_if.sv
// Stream bundle for fc_input_streamer: upstream capture port, downstream
// replay port and status flags.
interface fc_input_streamer_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 10
);
  logic                   i_valid;
  logic [DATA_WIDTH-1:0]  i_data;
  logic                   o_in_ready;
  logic                   o_valid;
  logic [DATA_WIDTH-1:0]  o_data;
  logic [INDEX_WIDTH-1:0] o_index;
  logic                   o_last;
  logic                   i_out_ready;
  logic                   o_busy;
  logic                   o_done;

  // Environment side: feeds words in, consumes the replayed stream.
  modport master (
    output i_valid, i_data, i_out_ready,
    input  o_in_ready, o_valid, o_data, o_index, o_last, o_busy, o_done
  );

  // Streamer side.
  modport slave (
    input  i_valid, i_data, i_out_ready,
    output o_in_ready, o_valid, o_data, o_index, o_last, o_busy, o_done
  );
endinterface

// File: rtl/fc_input_streamer.sv
// Captures one flattened feature vector into a RAM, then replays it word by
// word with node index and last flag under a valid/ready handshake.
module fc_input_streamer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUMBER_NODE = 576,
  parameter int unsigned INDEX_WIDTH = 10
) (
  input logic             clk,
  input logic             rst,
  fc_input_streamer_if.slave bus
);

  localparam int unsigned AddrW = (NUMBER_NODE > 1) ? $clog2(NUMBER_NODE) : 1;
  localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(NUMBER_NODE - 1);

  typedef enum logic [1:0] {StFill, StLoad, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [INDEX_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                   done_q;

  logic [DATA_WIDTH-1:0]  mem [NUMBER_NODE];
  logic [DATA_WIDTH-1:0]  rd_data_q;

  logic                   xfer;
  logic                   at_last;
  logic                   wr_en;
  logic                   rd_en;
  logic [AddrW-1:0]       rd_addr;

  assign at_last = (rd_cnt_q == LastIdx);
  assign xfer    = (state_q == StDrain) && bus.i_out_ready;
  // Reset wins over a coincident write.
  assign wr_en   = (state_q == StFill) && bus.i_valid && !rst;
  // LOAD fetches word 0; each transfer prefetches the following word so the
  // next beat is ready one cycle later.
  assign rd_en   = (state_q == StLoad) || (xfer && !at_last);
  assign rd_addr = (state_q == StLoad) ? '0 : AddrW'(rd_cnt_q + 1'b1);

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFill;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      done_q   <= xfer && at_last;
    end
  end

  // Buffer RAM: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q[AddrW-1:0]] <= bus.i_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  // Next-state and counter update.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      StFill: begin
        if (bus.i_valid) begin
          if (wr_cnt_q == LastIdx) begin
            wr_cnt_d = '0;
            state_d  = StLoad;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      StLoad: begin
        rd_cnt_d = '0;
        state_d  = StDrain;
      end
      StDrain: begin
        if (xfer) begin
          if (at_last) begin
            rd_cnt_d = '0;
            state_d  = StFill;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Outputs decoded from state; data/index are zero outside DRAIN.
  always_comb begin
    bus.o_in_ready = (state_q == StFill);
    bus.o_valid    = (state_q == StDrain);
    bus.o_busy     = (state_q != StFill);
    bus.o_done     = done_q;
    bus.o_data     = '0;
    bus.o_index    = '0;
    bus.o_last     = 1'b0;
    if (state_q == StDrain) begin
      bus.o_data  = rd_data_q;
      bus.o_index = rd_cnt_q;
      bus.o_last  = at_last;
    end
  end

endmodule

// File: tb/tb_fc_input_streamer.sv
// Bench for fc_input_streamer: a small (4-node) and a default (576-node)
// instance, checked against a phase/queue reference model.
module tb_fc_input_streamer;

  localparam int DW = 32;
  localparam int IW = 10;
  localparam int N4 = 4;
  localparam int NB = 576;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fc_input_streamer_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus4 ();
  fc_input_streamer_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus576 ();

  fc_input_streamer #(.DATA_WIDTH(DW), .NUMBER_NODE(N4), .INDEX_WIDTH(IW)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );
  fc_input_streamer #(.DATA_WIDTH(DW), .NUMBER_NODE(NB), .INDEX_WIDTH(IW)) dut576 (
    .clk(clk), .rst(rst), .bus(bus576)
  );

  // Reference model for the 4-node instance: either collecting a vector or
  // replaying it; replay starts two cycles after the vector completes.
  bit          m_fill = 1'b1;
  logic [31:0] m_vec[$];
  int          m_pos = 0;
  int          m_since = 0;
  bit          m_done = 1'b0;

  task automatic model_step();
    bit nd;
    nd = 1'b0;
    if (rst) begin
      m_fill = 1'b1; m_vec.delete(); m_pos = 0; m_since = 0;
    end else if (m_fill) begin
      if (bus4.i_valid) begin
        m_vec.push_back(bus4.i_data);
        if (m_vec.size() == N4) begin m_fill = 1'b0; m_since = 1; end
      end
    end else if (m_since < 2) begin
      m_since++;
    end else if (bus4.i_out_ready) begin
      if (m_pos == N4 - 1) begin
        m_fill = 1'b1; m_vec.delete(); m_pos = 0; nd = 1'b1;
      end else begin
        m_pos++;
      end
    end
    m_done = nd;
  endtask

  // {in_ready, valid, busy, done, last, index, data}; payload only when valid.
  function automatic logic [46:0] exp4();
    logic [46:0] e;
    logic        v;
    v = !m_fill && (m_since >= 2);
    e = {m_fill, v, !m_fill, m_done, 43'd0};
    if (v) e[42:0] = {(m_pos == N4 - 1), 10'(m_pos), m_vec[m_pos]};
    return e;
  endfunction

  function automatic logic [46:0] obs4();
    logic [46:0] o;
    o = {bus4.o_in_ready, bus4.o_valid, bus4.o_busy, bus4.o_done, 43'd0};
    if (bus4.o_valid) o[42:0] = {bus4.o_last, bus4.o_index, bus4.o_data};
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [46:0] rv;
    rv = {1'b1, 46'd0};
    rst = 1'b1;
    bus4.i_valid = 1'b1; bus4.i_data = $urandom; bus4.i_out_ready = 1'b1;
    bus576.i_valid = 1'b1; bus576.i_data = $urandom; bus576.i_out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({bus4.o_in_ready, bus4.o_valid, bus4.o_busy, bus4.o_done, bus4.o_last,
         bus4.o_index, bus4.o_data} !== rv) begin
      failures++;
      $display("FAIL reset4 got=%h exp=%h", {bus4.o_in_ready, bus4.o_valid, bus4.o_busy,
               bus4.o_done, bus4.o_last, bus4.o_index, bus4.o_data}, rv);
    end
    checks++;
    if ({bus576.o_in_ready, bus576.o_valid, bus576.o_busy, bus576.o_done, bus576.o_last,
         bus576.o_index, bus576.o_data} !== rv) begin
      failures++;
      $display("FAIL reset576 got=%h exp=%h", {bus576.o_in_ready, bus576.o_valid,
               bus576.o_busy, bus576.o_done, bus576.o_last, bus576.o_index, bus576.o_data}, rv);
    end
    rst = 1'b0;
    bus4.i_valid = 1'b0; bus576.i_valid = 1'b0; bus576.i_out_ready = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] words [4];
    int first_valid, done_cnt;
    words = '{32'h11, 32'h22, 32'h33, 32'h44};
    first_valid = -1; done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      bus4.i_valid = (c < 4);
      bus4.i_data = (c < 4) ? words[c] : 32'h0;
      bus4.i_out_ready = 1'b1;
      @(negedge clk);
      if (bus4.o_valid && first_valid < 0) first_valid = c;
      if (bus4.o_done) done_cnt++;
      checks++;
      if (obs4() !== exp4()) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", c, obs4(), exp4());
      end
      tick();
    end
    checks++;
    if (first_valid - 3 !== 2) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=2", first_valid - 3);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL basic_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] plan[$];
    int hold;
    hold = 0;
    for (int i = 0; i < 4; i++) plan.push_back($urandom);
    for (int c = 0; c < 20; c++) begin
      bus4.i_valid = m_fill && (plan.size() > 0);
      bus4.i_data = (plan.size() > 0) ? plan[0] : 32'h0;
      bus4.i_out_ready = 1'b1;
      if (!m_fill && m_since >= 2 && m_pos == 1 && hold < 3) begin
        bus4.i_out_ready = 1'b0; hold++;
      end
      @(negedge clk);
      checks++;
      if (obs4() !== exp4()) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, obs4(), exp4());
      end
      if (bus4.i_valid && m_fill) void'(plan.pop_front());
      tick();
    end
  endtask

  task automatic test_gapped();
    for (int c = 0; c < 20; c++) begin
      bus4.i_valid = (c < 8) && (c % 2 == 0);
      bus4.i_data = $urandom;
      bus4.i_out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (obs4() !== exp4()) begin
        failures++;
        $display("FAIL gapped cyc=%0d got=%h exp=%h", c, obs4(), exp4());
      end
      tick();
    end
  endtask

  task automatic test_blocked();
    logic [31:0] plan[$];
    for (int i = 0; i < 4; i++) plan.push_back($urandom);
    for (int i = 0; i < 4; i++) plan.push_back(32'hA0 + 32'(i));
    for (int c = 0; c < 30; c++) begin
      if (m_fill) begin
        bus4.i_valid = (plan.size() > 0);
        bus4.i_data = (plan.size() > 0) ? plan[0] : 32'h0;
      end else begin
        bus4.i_valid = 1'b1;
        bus4.i_data = 32'hDEAD;
      end
      bus4.i_out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (obs4() !== exp4()) begin
        failures++;
        $display("FAIL blocked cyc=%0d got=%h exp=%h", c, obs4(), exp4());
      end
      if (bus4.i_valid && m_fill) void'(plan.pop_front());
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] plan[$];
    for (int c = 0; c < 2; c++) begin
      bus4.i_valid = 1'b1; bus4.i_data = $urandom; bus4.i_out_ready = 1'b1;
      tick();
    end
    rst = 1'b1; bus4.i_valid = 1'b1; bus4.i_data = 32'hBAD;
    tick();
    rst = 1'b0; bus4.i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus4.o_in_ready, bus4.o_valid, bus4.o_busy, bus4.o_done, bus4.o_last,
         bus4.o_index, bus4.o_data} !== {1'b1, 46'd0}) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", {bus4.o_in_ready, bus4.o_valid, bus4.o_busy,
               bus4.o_done, bus4.o_last, bus4.o_index, bus4.o_data}, {1'b1, 46'd0});
    end
    tick();
    for (int i = 5; i <= 8; i++) plan.push_back(32'(i));
    for (int c = 0; c < 14; c++) begin
      bus4.i_valid = m_fill && (plan.size() > 0);
      bus4.i_data = (plan.size() > 0) ? plan[0] : 32'h0;
      bus4.i_out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (obs4() !== exp4()) begin
        failures++;
        $display("FAIL reset_mid_drain cyc=%0d got=%h exp=%h", c, obs4(), exp4());
      end
      if (bus4.i_valid && m_fill) void'(plan.pop_front());
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] plan[$];
    int done_cnt;
    done_cnt = 0;
    for (int i = 0; i < 3 * N4; i++) plan.push_back($urandom);
    for (int c = 0; c < 200; c++) begin
      if (m_fill) begin
        bus4.i_valid = (plan.size() > 0) && ($urandom % 10 < 6);
        bus4.i_data = (plan.size() > 0) ? plan[0] : 32'h0;
      end else begin
        bus4.i_valid = $urandom % 2;
        bus4.i_data = $urandom;
      end
      bus4.i_out_ready = ($urandom % 10 < 6);
      @(negedge clk);
      if (bus4.o_done) done_cnt++;
      checks++;
      if (obs4() !== exp4()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, obs4(), exp4());
      end
      if (bus4.i_valid && m_fill) void'(plan.pop_front());
      tick();
    end
    checks++;
    if (done_cnt !== 3) begin
      failures++;
      $display("FAIL random_done_count got=%0d exp=3", done_cnt);
    end
    bus4.i_valid = 1'b0;
  endtask

  task automatic test_full576();
    int  exp_idx, done_cnt, first_valid, tail;
    bit  ready;
    exp_idx = 0; done_cnt = 0; first_valid = -1; tail = 0;
    bus576.i_out_ready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      bus576.i_valid = 1'b1; bus576.i_data = 32'(k);
      @(negedge clk);
      checks++;
      if (bus576.o_in_ready !== 1'b1 || bus576.o_valid !== 1'b0) begin
        failures++;
        $display("FAIL full_fill k=%0d in_ready=%b valid=%b exp in_ready=1 valid=0",
                 k, bus576.o_in_ready, bus576.o_valid);
      end
      tick();
    end
    bus576.i_valid = 1'b0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      ready = ($urandom % 4) != 0;
      bus576.i_out_ready = ready;
      @(negedge clk);
      if (bus576.o_done) done_cnt++;
      if (bus576.o_valid) begin
        if (first_valid < 0) first_valid = cyc;
        checks++;
        if (exp_idx >= NB || bus576.o_index !== 10'(exp_idx) ||
            bus576.o_data !== 32'(exp_idx) || bus576.o_last !== (exp_idx == NB - 1)) begin
          failures++;
          $display("FAIL full_drain got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                   bus576.o_index, bus576.o_data, bus576.o_last, exp_idx, exp_idx,
                   (exp_idx == NB - 1));
        end
        if (ready) exp_idx++;
      end
      tick();
      if (exp_idx >= NB) tail++;
      if (tail == 4) break;
    end
    checks++;
    if (first_valid !== 2) begin
      failures++;
      $display("FAIL full_latency got=%0d exp=2", first_valid);
    end
    checks++;
    if (exp_idx !== NB) begin
      failures++;
      $display("FAIL full_count got=%0d exp=%0d", exp_idx, NB);
    end
    checks++;
    if (done_cnt !== 1 || bus576.o_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_done got done=%0d in_ready=%b exp done=1 in_ready=1",
               done_cnt, bus576.o_in_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus4.i_valid = 1'b0; bus4.i_data = '0; bus4.i_out_ready = 1'b0;
    bus576.i_valid = 1'b0; bus576.i_data = '0; bus576.i_out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_blocked();
    test_reset_mid();
    test_random();
    test_full576();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
